// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame-length and counter-width
// helpers. Used by the transmitter and intended for a future receiver.
package uart_pkg;

  // Encoding is fixed (exported on the debug port); 5..7 are illegal.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Bits per frame: start + data + optional parity + stop.
  function automatic int frame_len(input int data_bits, input int stop_bits,
                                   input int parity_bits);
    return 1 + data_bits + parity_bits + stop_bits;
  endfunction

  // Width of a counter that runs 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud generator: counts 0..CLK_DIV-1 while enabled and pulses bit_tick on the
// last count, then wraps, so bit boundaries never drift across a frame.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);

  localparam int W = cnt_width(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  assign bit_tick = enable && (cnt == LAST);

  // Count clocks within the current bit; clear restarts the bit on accept.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= bit_tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB-first,
// optional parity bit, STOP_BITS stop bits. One word per valid/ready handshake.
// Optional parity is compiled in by defining UART_TX_PARITY_EN.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 868,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done,
  output logic [2:0]           state
);

  if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
    $error("uart_tx_param: CLK_DIV must be 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx_param: PARITY_ODD must be 0 or 1");
  end

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  state_t               state_q, state_d;
  logic                 tx_d, done_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [3:0]           idx_q, idx_d;
  logic                 bit_tick;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign tx_ready = (state_q == IDLE);
  assign busy     = ~tx_ready;
  assign state    = state_q;

  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (tx_valid && tx_ready),
    .enable   (busy),
    .bit_tick (bit_tick)
  );

  // Next-state, next-bit and shift logic; everything advances on bit_tick.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    tx_d    = tx;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_valid) begin
          state_d = START;
          tx_d    = 1'b0;
          shreg_d = tx_data;
          idx_d   = '0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_data ^ PARITY_ODD[0];
`endif
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
            idx_d   = idx_q + 4'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
          idx_d   = '0;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (bit_tick) begin
          if (idx_q == LAST_STOP) begin
            state_d = IDLE;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State, line and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx      <= 1'b1;
      tx_done <= 1'b0;
      shreg_q <= '0;
      idx_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tx      <= tx_d;
      tx_done <= done_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: three instances cover 8N1 / 8N2 and
// 5-bit / CLK_DIV=2 configurations; parity expectations follow UART_TX_PARITY_EN.
module tb_uart_tx_param;

  localparam int P =
`ifdef UART_TX_PARITY_EN
    1;
`else
    0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: CLK_DIV=4, 8 data, 1 stop, even parity
  logic       valid_a = 1'b0, ready_a, tx_a, busy_a, done_a;
  logic [7:0] data_a = '0;
  logic [2:0] state_a;
  // Instance B: CLK_DIV=4, 8 data, 2 stop, even parity
  logic       valid_b = 1'b0, ready_b, tx_b, busy_b, done_b;
  logic [7:0] data_b = '0;
  logic [2:0] state_b;
  // Instance C: CLK_DIV=2, 5 data, 1 stop, odd parity
  logic       valid_c = 1'b0, ready_c, tx_c, busy_c, done_c;
  logic [4:0] data_c = '0;
  logic [2:0] state_c;

  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_a (
    .clk(clk), .rst(rst), .tx_data(data_a), .tx_valid(valid_a), .tx_ready(ready_a),
    .tx(tx_a), .busy(busy_a), .tx_done(done_a), .state(state_a));
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) u_b (
    .clk(clk), .rst(rst), .tx_data(data_b), .tx_valid(valid_b), .tx_ready(ready_b),
    .tx(tx_b), .busy(busy_b), .tx_done(done_b), .state(state_b));
  uart_tx_param #(.CLK_DIV(2), .DATA_BITS(5), .STOP_BITS(1), .PARITY_ODD(1)) u_c (
    .clk(clk), .rst(rst), .tx_data(data_c), .tx_valid(valid_c), .tx_ready(ready_c),
    .tx(tx_c), .busy(busy_c), .tx_done(done_c), .state(state_c));

  int sel = 0;
  logic       tx_m, ready_m, busy_m, done_m;
  logic [2:0] state_m;

  always_comb begin
    tx_m = tx_a; ready_m = ready_a; busy_m = busy_a; done_m = done_a; state_m = state_a;
    case (sel)
      1: begin tx_m = tx_b; ready_m = ready_b; busy_m = busy_b; done_m = done_b; state_m = state_b; end
      2: begin tx_m = tx_c; ready_m = ready_c; busy_m = busy_c; done_m = done_c; state_m = state_c; end
      default: ;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int s, input logic v, input logic [8:0] w);
    case (s)
      0: begin valid_a = v; data_a = w[7:0]; end
      1: begin valid_b = v; data_b = w[7:0]; end
      default: begin valid_c = v; data_c = w[4:0]; end
    endcase
  endtask

  // Send one word and check every clock of the frame against a bit-level model.
  // drive: raise valid first; hold: keep valid high with nxt for back-to-back;
  // disturb: toggle data and pulse valid mid-frame.
  task automatic run_frame(input int s, input logic [8:0] w, input int div,
                           input int nd, input int ns, input int odd,
                           input bit drive, input bit hold, input logic [8:0] nxt,
                           input bit disturb);
    int f, b;
    logic [8:0] m;
    logic par, exp_bit;
    sel = s;
    f   = 1 + nd + P + ns;
    m   = w & 9'((1 << nd) - 1);
    par = (^m) ^ odd[0];
    if (drive) begin
      @(negedge clk);
      check($sformatf("s%0d ready_before", s), ready_m, 1);
      set_in(s, 1'b1, w);
    end
    @(posedge clk);
    for (int k = 0; k < f * div; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (hold) set_in(s, 1'b1, nxt);
        else      set_in(s, 1'b0, w);
        check($sformatf("s%0d state_start", s), state_m, 3'd1);
      end
      if (disturb && k == 10) set_in(s, 1'b1, ~w);
      if (disturb && k == 12) set_in(s, 1'b0, ~w);
      b = k / div;
      if (b == 0)                    exp_bit = 1'b0;
      else if (b <= nd)              exp_bit = m[b-1];
      else if (P == 1 && b == nd+1)  exp_bit = par;
      else                           exp_bit = 1'b1;
      check($sformatf("s%0d w%0h tx bit%0d k%0d", s, w, b, k), tx_m, exp_bit);
      check($sformatf("s%0d busy k%0d", s, k), busy_m, 1);
    end
    @(negedge clk);
    check($sformatf("s%0d done_pulse", s), done_m, 1);
    check($sformatf("s%0d state_idle", s), state_m, 3'd0);
    check($sformatf("s%0d ready_end", s), ready_m, 1);
    check($sformatf("s%0d tx_idle_gap", s), tx_m, 1);
    if (!hold) begin
      @(negedge clk);
      check($sformatf("s%0d done_clear", s), done_m, 0);
      check($sformatf("s%0d no_reaccept", s), state_m, 3'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_done;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      check($sformatf("s%0d rst_state", s), state_m, 3'd0);
      check($sformatf("s%0d rst_tx", s), tx_m, 1);
      check($sformatf("s%0d rst_ready", s), ready_m, 1);
      check($sformatf("s%0d rst_done", s), done_m, 0);
    end
    rst = 1'b0;

    run_frame(0, 9'h55, 4, 8, 1, 0, 1, 0, 9'h0, 0);
    run_frame(0, 9'h07, 4, 8, 1, 0, 1, 0, 9'h0, 0);
    run_frame(2, 9'h07, 2, 5, 1, 1, 1, 0, 9'h0, 0);
    run_frame(2, 9'h1F, 2, 5, 1, 1, 1, 0, 9'h0, 0);
    run_frame(1, 9'hA3, 4, 8, 2, 0, 1, 1, 9'h3C, 0);
    run_frame(1, 9'h3C, 4, 8, 2, 0, 0, 0, 9'h0, 0);
    run_frame(0, 9'h96, 4, 8, 1, 0, 1, 0, 9'h0, 1);

    // Abort a frame with reset partway through.
    sel = 0;
    @(negedge clk);
    set_in(0, 1'b1, 9'h5A);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 9'h5A);
    repeat (16) @(negedge clk);
    check("abort_pre_busy", busy_m, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx", tx_m, 1);
    check("abort_state", state_m, 3'd0);
    check("abort_ready", ready_m, 1);
    check("abort_done", done_m, 0);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_m !== 1'b0) seen_done = 1'b1;
    end
    check("abort_no_done", seen_done, 0);
    run_frame(0, 9'hC3, 4, 8, 1, 0, 1, 0, 9'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter that replaces the split FSM, external baud-counter and bit-counter arrangement with a single self-contained block. It serialises one word per valid/ready handshake as start bit, DATA_BITS data bits LSB-first, an optional parity bit, and STOP_BITS stop bits. The internal baud generator is set by a clocks-per-bit parameter. The block sits between the system-side word source (FIFO or register) and the tx pin.

Parameters:
CLK_DIV, 868, clocks per serial bit (for example 100 MHz / 115200); legal range 2..65535.
DATA_BITS, 8, data bits per frame; legal range 5..9.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
tx_data  in  DATA_BITS  word to send; sampled only on handshake
tx_valid  in  1  source has a word
tx_ready  out  1  block can accept a word; equals (state==IDLE)
tx  out  1  serial line, registered, idle high
busy  out  1  equals ~tx_ready
tx_done  out  1  one-cycle pulse when the final stop bit completes
state  out  3  current FSM state, for debug

Behaviour:
- Reset (synchronous, at the clk edge with rst=1):
  - state=IDLE, tx=1, tx_done=0, baud count=0, bit index=0, shift register=0.
  - tx_ready=1 from the first cycle after reset.
- State encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; values 5..7 are illegal and recover to IDLE on the next edge with tx=1.
- Handshake: a transfer occurs on an edge where tx_valid && tx_ready. tx_data is latched into the shift register on that edge. tx_data and tx_valid are ignored while busy.
- Latency: on accept edge E0, state goes to START and tx=0. Every bit is held for exactly CLK_DIV cycles.
- Baud counter:
  - Width $clog2(CLK_DIV).
  - Cleared on accept and counts 0..CLK_DIV-1.
  - bit_tick fires when count==CLK_DIV-1; the counter then wraps to 0.
  - No drift across the frame.
- Transitions (all taken on bit_tick):
  - START -> DATA, driving tx = data[0].
  - DATA shifts out LSB-first. After DATA_BITS bits it goes to PARITY if compiled in, otherwise to STOP.
  - PARITY drives tx = ^data ^ PARITY_ODD.
  - STOP drives tx=1 for STOP_BITS bit-times, then returns to IDLE.
- Frame length: F = 1 + DATA_BITS + P + STOP_BITS bits, where P is 1 if parity is compiled in, else 0.
- Frame end: state returns to IDLE at edge E0 + F*CLK_DIV. tx_done=1 for exactly the following cycle.
- Back-to-back: if tx_valid is already high in the first IDLE cycle, the next accept happens on that cycle's edge. The inter-frame idle is therefore exactly 1 extra clk at tx=1, never 0.
- rst mid-frame: frame aborted, all reset values restored on that edge, tx=1 immediately. No tx_done pulse.
- Parameter checks: an elaboration-time check fails on CLK_DIV<2, DATA_BITS outside 5..9, or STOP_BITS not in {1,2}.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state present; one parity bit is inserted after the data bits.
  - Sense set by PARITY_ODD; F includes P=1.
- Undefined:
  - PARITY state and parity logic are absent; PARITY_ODD is ignored.
  - DATA -> STOP directly; P=0.
  - Encoding 3 is treated as illegal (recovers to IDLE).

Decomposition:
- Package uart_pkg holds:
  - State encoding constants (IDLE..STOP).
  - Frame-length function F(DATA_BITS, STOP_BITS, P).
  - Counter-width helper.
  - Shared with a future parametrised receiver.
- Sub-module uart_baud_gen (parameter CLK_DIV; ports clk, rst, clear, enable, bit_tick) is natural. The transmitter instantiates it and the receiver will reuse it.

Test Plan:
- CLK_DIV=4, DATA_BITS=8, STOP_BITS=1, no parity. Send 0x55 -> tx is 0 for 4 cycles, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then 1 for 4 cycles. tx_ready=0 for 40 cycles. tx_done pulses at cycle 41.
- UART_TX_PARITY_EN, PARITY_ODD=0. Send 0x07 -> parity bit 1 and F=11 (44 cycles). With PARITY_ODD=1, 0x07 gives parity bit 0.
- STOP_BITS=2, tx_valid held high with 0xA3 then 0x3C -> each frame is 11 bits. Exactly one idle clk between frames. Both words decode correctly LSB-first.
- tx_data toggled and tx_valid pulsed mid-frame -> transmitted word unchanged and no second accept.
- rst asserted at cycle 17 of a frame -> next edge gives tx=1, state=IDLE, tx_ready=1, no tx_done. A new frame sent after reset is correct.
- CLK_DIV=2, DATA_BITS=5, send 0x1F -> 14-cycle frame (7 bits × 2 clk). Baud counter wraps without drift.
